// File: rtl/tdm_demux_1x4.sv
// tdm_demux_1x4: four-slot TDM demultiplexer with frame-sync lock tracking.
// Slots 0..2 are collected in shadow registers. The slot-3 sample
// updates all four channel outputs together on a single edge.
module tdm_demux_1x4 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic             frame_valid,
  output logic [1:0]       slot,
  output logic             locked,
  output logic             sync_err
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [1:0]       slot_reg, slot_next;
  logic [WIDTH-1:0] shadow_reg [0:2];
  logic [WIDTH-1:0] shadow_next [0:2];
  logic [WIDTH-1:0] y_reg [0:3];
  logic [WIDTH-1:0] y_next [0:3];
  logic             frame_valid_reg, frame_valid_next;
  logic             sync_err_reg, sync_err_next;

  // Next-state logic: every sample acceptance decision is made here.
  // Unaccepted cycles (en=0) keep all state and leave the pulses low.
  always_comb begin
    state_next       = state_reg;
    slot_next        = slot_reg;
    shadow_next      = shadow_reg;
    y_next           = y_reg;
    frame_valid_next = 1'b0;
    sync_err_next    = 1'b0;

    if (en) begin
      if (state_reg == HUNT) begin
        // Samples without sync are dropped until the first frame start.
        if (frame_sync) begin
          shadow_next[0] = din;
          slot_next      = 2'd1;
          state_next     = LOCKED;
        end
      end else if (frame_sync) begin
        // Sync restarts the frame. Only slot 0 is a legal place for it.
        // Elsewhere, the partial frame is dropped and an error is flagged.
        sync_err_next  = (slot_reg != 2'd0);
        shadow_next[0] = din;
        slot_next      = 2'd1;
      end else begin
        case (slot_reg)
          2'd1: begin
            shadow_next[1] = din;
            slot_next      = 2'd2;
          end
          2'd2: begin
            shadow_next[2] = din;
            slot_next      = 2'd3;
          end
          2'd3: begin
            // Frame complete: publish all four channels on this edge.
            y_next[0]        = shadow_reg[0];
            y_next[1]        = shadow_reg[1];
            y_next[2]        = shadow_reg[2];
            y_next[3]        = din;
            frame_valid_next = 1'b1;
            slot_next        = 2'd0;
          end
          default: begin
            // Slot 0 without sync means framing was lost.
            sync_err_next = 1'b1;
            state_next    = HUNT;
            slot_next     = 2'd0;
          end
        endcase
      end
    end
  end

  // State and output registers; reset overrides every input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= HUNT;
      slot_reg        <= 2'd0;
      frame_valid_reg <= 1'b0;
      sync_err_reg    <= 1'b0;
      for (int i = 0; i < 3; i++) shadow_reg[i] <= '0;
      for (int i = 0; i < 4; i++) y_reg[i] <= '0;
    end else begin
      state_reg       <= state_next;
      slot_reg        <= slot_next;
      frame_valid_reg <= frame_valid_next;
      sync_err_reg    <= sync_err_next;
      shadow_reg      <= shadow_next;
      y_reg           <= y_next;
    end
  end

  assign y0          = y_reg[0];
  assign y1          = y_reg[1];
  assign y2          = y_reg[2];
  assign y3          = y_reg[3];
  assign frame_valid = frame_valid_reg;
  assign sync_err    = sync_err_reg;
  assign slot        = slot_reg;
  assign locked      = (state_reg == LOCKED);

endmodule
